// File: rtl/display_pkg.sv
// display_pkg: shared FSM state type and display constants for display_scan_controller.
package display_pkg;
    typedef enum logic {ST_ACTIVE, ST_GUARD} scan_state_e;
    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;
    function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction
endpackage

// File: rtl/refresh_tick_gen.sv
// refresh_tick_gen: dwell counter; done is high on the cycle the count reaches limit.
module refresh_tick_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else cnt <= clear ? '0 : cnt + W'(1);
    assign done = cnt == limit;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: 4-digit multiplexed display scanner with frame-synchronous loads.
// Define DISPLAY_SCAN_LZB_EN to blank leading zeros (digit 0 is never blanked).
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  digit_value,
    output logic        digit_blank,
    output logic [3:0]  an_n,
    output logic        frame_done
);
    localparam int MAX_DWELL = REFRESH_DIV > GUARD_CYCLES ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CW = $clog2(MAX_DWELL);
    localparam logic [CW-1:0] ACT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_CYCLES - 1);

    scan_state_e state, state_nxt;
    logic        run;
    logic [1:0]  idx;
    logic [15:0] disp_reg, shadow;
    logic        pending, done, wrap, accept, lz;

    // run keeps everything dark for the first cycle after reset so the scan starts cleanly at idx 0
    refresh_tick_gen #(.W(CW)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!run || done),
        .limit   (state == ST_ACTIVE ? ACT_LAST : GRD_LAST),
        .done    (done)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= ST_ACTIVE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = (run && done) ? (state == ST_ACTIVE ? ST_GUARD : ST_ACTIVE) : state;
    end

    assign wrap   = run && done && state == ST_GUARD && idx == 2'd3;
    assign accept = load_valid && !pending;

    // a load accepted on the wrap cycle lands in shadow after the copy, so it waits a full frame
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            run        <= 1'b0;
            idx        <= 2'd0;
            disp_reg   <= 16'h0000;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            run        <= 1'b1;
            frame_done <= wrap;
            pending    <= accept || (pending && !wrap);
            if (run && done && state == ST_GUARD) idx <= idx + 2'd1;
            if (wrap && pending) disp_reg <= shadow;
            if (accept) shadow <= load_data;
        end

`ifdef DISPLAY_SCAN_LZB_EN
    assign lz = idx != 2'd0 && (disp_reg >> {idx, 2'b00}) == 16'h0000;
`else
    assign lz = 1'b0;
`endif

    always_comb begin
        digit_blank = !run || state == ST_GUARD || lz;
        digit_value = run ? disp_reg[{idx, 2'b00} +: 4] : 4'h0;
        an_n        = digit_blank ? ANODE_OFF : anode_sel_n(idx);
    end

    assign load_ready = !pending;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed bench, REFRESH_DIV=8 / GUARD_CYCLES=2 (40-cycle frame).
module tb_display_scan_controller;
    logic        clk = 1'b0, reset_n = 1'b0, load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        load_ready, digit_blank, frame_done;
    logic [3:0]  digit_value, an_n;
    int checks = 0, fails = 0, pos = 0;
`ifdef DISPLAY_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    display_scan_controller #(.REFRESH_DIV(8), .GUARD_CYCLES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .digit_value (digit_value),
        .digit_blank (digit_blank),
        .an_n        (an_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // pos is the frame position (0..39) of the cycle currently being sampled
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        pos = (pos + 1) % 40;
    endtask

    task automatic goto(input int p);
        for (int i = 0; i < 40 && pos != p; i++) step();
    endtask

    function automatic logic [3:0] exp_an(input int p, input logic [15:0] v);
        int d = p / 10;
        logic off = (p % 10) >= 8 || (LZB && d > 0 && (v >> (4 * d)) == 16'h0);
        return off ? 4'b1111 : ~(4'b0001 << d);
    endfunction

    function automatic logic [3:0] exp_val(input int p, input logic [15:0] v);
        return v[4 * (p / 10) +: 4];
    endfunction

    task automatic test_reset();
        #12;
        checks += 5;
        if (an_n !== 4'b1111) begin fails++; $display("FAIL reset_an_n: got %b expected 1111", an_n); end
        if (digit_blank !== 1'b1) begin fails++; $display("FAIL reset_blank: got %b expected 1", digit_blank); end
        if (digit_value !== 4'h0) begin fails++; $display("FAIL reset_value: got %h expected 0", digit_value); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        pos = 39;
    endtask

    task automatic test_scan_sequence();
        for (int c = 0; c < 80; c++) begin
            step();
            checks += 3;
            if (an_n !== exp_an(pos, 16'h0)) begin fails++; $display("FAIL scan_an_n c=%0d: got %b expected %b", c, an_n, exp_an(pos, 16'h0)); end
            if (digit_value !== 4'h0) begin fails++; $display("FAIL scan_value c=%0d: got %h expected 0", c, digit_value); end
            if (frame_done !== (pos == 0 && c > 0)) begin fails++; $display("FAIL scan_frame_done c=%0d: got %b expected %b", c, frame_done, pos == 0 && c > 0); end
        end
    endtask

    task automatic test_load();
        goto(15);
        checks++;
        if (load_ready !== 1'b1) begin fails++; $display("FAIL load_ready_before: got %b expected 1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        load_data  = 16'hffff;
        while (pos != 0) begin
            checks += 3;
            if (load_ready !== 1'b0) begin fails++; $display("FAIL load_ready_pending pos=%0d: got %b expected 0", pos, load_ready); end
            if (digit_value !== 4'h0) begin fails++; $display("FAIL load_no_tear pos=%0d: got %h expected 0", pos, digit_value); end
            if (an_n !== exp_an(pos, 16'h0)) begin fails++; $display("FAIL load_an_old pos=%0d: got %b expected %b", pos, an_n, exp_an(pos, 16'h0)); end
            step();
        end
        checks += 2;
        if (frame_done !== 1'b1) begin fails++; $display("FAIL load_wrap_frame_done: got %b expected 1", frame_done); end
        if (load_ready !== 1'b1) begin fails++; $display("FAIL load_ready_after_wrap: got %b expected 1", load_ready); end
        for (int i = 0; i < 40; i++) begin
            checks += 2;
            if (digit_value !== exp_val(pos, 16'h1234)) begin fails++; $display("FAIL load_value pos=%0d: got %h expected %h", pos, digit_value, exp_val(pos, 16'h1234)); end
            if (an_n !== exp_an(pos, 16'h1234)) begin fails++; $display("FAIL load_an_n pos=%0d: got %b expected %b", pos, an_n, exp_an(pos, 16'h1234)); end
            step();
        end
    endtask

    task automatic test_pending_ignore();
        goto(5);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        step();
        load_data = 16'h9abc;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (load_ready !== 1'b0) begin fails++; $display("FAIL ignore_ready pos=%0d: got %b expected 0", pos, load_ready); end
            step();
        end
        load_valid = 1'b0;
        goto(0);
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (digit_value !== exp_val(pos, 16'h5678)) begin fails++; $display("FAIL ignore_value pos=%0d: got %h expected %h", pos, digit_value, exp_val(pos, 16'h5678)); end
            step();
        end
    endtask

    task automatic test_wrap_load();
        goto(39);
        checks++;
        if (load_ready !== 1'b1) begin fails++; $display("FAIL wrap_ready_before: got %b expected 1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h4321;
        step();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin fails++; $display("FAIL wrap_ready_after: got %b expected 0", load_ready); end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (digit_value !== exp_val(pos, 16'h5678)) begin fails++; $display("FAIL wrap_old_value pos=%0d: got %h expected %h", pos, digit_value, exp_val(pos, 16'h5678)); end
            step();
        end
        checks++;
        if (load_ready !== 1'b1) begin fails++; $display("FAIL wrap_ready_applied: got %b expected 1", load_ready); end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (digit_value !== exp_val(pos, 16'h4321)) begin fails++; $display("FAIL wrap_new_value pos=%0d: got %h expected %h", pos, digit_value, exp_val(pos, 16'h4321)); end
            step();
        end
    endtask

    task automatic test_reset_midframe();
        goto(5);
        load_valid = 1'b1;
        load_data  = 16'hdead;
        step();
        load_valid = 1'b0;
        goto(22);
        checks++;
        if (an_n !== 4'b1011) begin fails++; $display("FAIL mid_idx2_an_n: got %b expected 1011", an_n); end
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (an_n !== 4'b1111) begin fails++; $display("FAIL mid_reset_an_n: got %b expected 1111", an_n); end
        if (digit_blank !== 1'b1) begin fails++; $display("FAIL mid_reset_blank: got %b expected 1", digit_blank); end
        if (digit_value !== 4'h0) begin fails++; $display("FAIL mid_reset_value: got %h expected 0", digit_value); end
        if (frame_done !== 1'b0) begin fails++; $display("FAIL mid_reset_frame_done: got %b expected 0", frame_done); end
        if (load_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b expected 1", load_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        pos = 39;
        step();
        for (int i = 0; i < 80; i++) begin
            checks += 3;
            if (an_n !== exp_an(pos, 16'h0)) begin fails++; $display("FAIL mid_after_an_n pos=%0d: got %b expected %b", pos, an_n, exp_an(pos, 16'h0)); end
            if (digit_value !== 4'h0) begin fails++; $display("FAIL mid_after_value pos=%0d: got %h expected 0", pos, digit_value); end
            if (load_ready !== 1'b1) begin fails++; $display("FAIL mid_after_ready pos=%0d: got %b expected 1", pos, load_ready); end
            step();
        end
    endtask

    task automatic test_lzb();
        logic [3:0] an_exp [4];
        logic [3:0] val_exp [4];
        an_exp  = '{4'b1110, 4'b1101, LZB ? 4'b1111 : 4'b1011, LZB ? 4'b1111 : 4'b0111};
        val_exp = '{4'h0, 4'h5, 4'h0, 4'h0};
        goto(5);
        load_valid = 1'b1;
        load_data  = 16'h0050;
        step();
        load_valid = 1'b0;
        goto(0);
        for (int d = 0; d < 4; d++) begin
            goto(10 * d);
            checks += 3;
            if (an_n !== an_exp[d]) begin fails++; $display("FAIL lzb_an_n digit=%0d: got %b expected %b", d, an_n, an_exp[d]); end
            if (digit_value !== val_exp[d]) begin fails++; $display("FAIL lzb_value digit=%0d: got %h expected %h", d, digit_value, val_exp[d]); end
            if (digit_blank !== (an_exp[d] == 4'b1111)) begin fails++; $display("FAIL lzb_blank digit=%0d: got %b expected %b", d, digit_blank, an_exp[d] == 4'b1111); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_load();
        test_pending_ignore();
        test_wrap_load();
        test_reset_midframe();
        test_lzb();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
